// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch serial command front end.
// Holds the ASCII command bytes, the UART receiver state encoding and a
// case-folding helper used by the command decoder.
package stopwatch_pkg;

  // Upper-case ASCII command characters; lower case is accepted via fold_case
  localparam logic [7:0] CMD_GO    = 8'h47;  // 'G'
  localparam logic [7:0] CMD_PAUSE = 8'h50;  // 'P'
  localparam logic [7:0] CMD_UP    = 8'h55;  // 'U'
  localparam logic [7:0] CMD_DOWN  = 8'h44;  // 'D'
  localparam logic [7:0] CMD_CLR   = 8'h43;  // 'C'
  localparam logic [7:0] CMD_RST   = 8'h52;  // 'R'

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } rx_state_e;

  // Setting bit 5 maps 'A'..'Z' onto 'a'..'z'; a folded byte equals a folded
  // letter only when the original was that letter in either case.
  function automatic logic [7:0] fold_case(input logic [7:0] b);
    return b | 8'h20;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling.
// Ports:
//   clk, rst_n     - system clock, async active-low reset
//   rx             - asynchronous serial line, idle high
//   rx_done        - one-cycle pulse, registered on a good stop-bit sample
//   rx_byte        - last received byte (LSB first on the line)
//   frame_err      - one-cycle pulse, registered on a low stop-bit sample
module uart_rx
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 19200,
  parameter int unsigned DBIT   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  output logic            rx_done,
  output logic [DBIT-1:0] rx_byte,
  output logic            frame_err
);

  localparam int unsigned DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned NW  = (DBIT > 1) ? $clog2(DBIT) : 1;

  // Free-running 16x-baud tick generator
  logic [TW-1:0] tcnt_q;
  logic          tick;

  assign tick = (tcnt_q == TW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt_q <= '0;
    else        tcnt_q <= tick ? '0 : tcnt_q + TW'(1);
  end

  // Two-flop synchroniser, reset to the idle line level
  logic [1:0] sync_q;
  logic       rxs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  assign rxs = sync_q[1];

  // Receiver FSM
  rx_state_e       state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] byte_q, byte_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          s_d     = '0;
          state_d = START;
        end
      end
      // Re-check the line at mid start bit to reject glitches
      START: begin
        if (tick) begin
          if (s_q == 4'd7) begin
            if (!rxs) begin
              s_d     = '0;
              n_d     = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == 4'd15) begin
            byte_d = {rxs, byte_q[DBIT-1:1]};
            s_d    = '0;
            if (n_q == NW'(DBIT - 1)) state_d = STOP;
            else                      n_d     = n_q + NW'(1);
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == 4'd15) begin
            if (rxs) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = WAIT_HI;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      // A held-low break must not be seen as a stream of frames
      WAIT_HI: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_done   = done_q;
  assign rx_byte   = byte_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Serial command front end for the stopwatch: decodes single ASCII command
// characters received over UART into the counter's control signals.
// Ports:
//   clk, rst_n - system clock, async active-low reset
//   rx         - asynchronous serial line, idle high
//   go         - level, 1 = stopwatch running
//   up         - level, 1 = count up, 0 = count down
//   clr        - one-cycle clear pulse
//   cmd_ack    - one-cycle pulse when a recognised command is applied
//   cmd_err    - one-cycle pulse on an unknown byte or a framing error
module uart_cmd_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 19200,
  parameter int unsigned DBIT   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic go,
  output logic up,
  output logic clr,
  output logic cmd_ack,
  output logic cmd_err
);

  localparam logic [7:0] LC_GO    = fold_case(CMD_GO);
  localparam logic [7:0] LC_PAUSE = fold_case(CMD_PAUSE);
  localparam logic [7:0] LC_UP    = fold_case(CMD_UP);
  localparam logic [7:0] LC_DOWN  = fold_case(CMD_DOWN);
  localparam logic [7:0] LC_CLR   = fold_case(CMD_CLR);
  localparam logic [7:0] LC_RST   = fold_case(CMD_RST);

  logic            rx_done;
  logic            frame_err;
  logic [DBIT-1:0] rx_byte;
  logic [7:0]      cmd;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .DBIT   (DBIT)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_done   (rx_done),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  assign cmd = fold_case(8'(rx_byte));

  logic go_q, go_d, up_q, up_d, clr_q, clr_d, ack_q, ack_d, err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_q  <= 1'b0;
      up_q  <= 1'b1;
      clr_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      go_q  <= go_d;
      up_q  <= up_d;
      clr_q <= clr_d;
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end

  // Command decode; a framing error never coincides with rx_done
  always_comb begin
    go_d  = go_q;
    up_d  = up_q;
    clr_d = 1'b0;
    ack_d = 1'b0;
    err_d = frame_err;
    if (rx_done) begin
      ack_d = 1'b1;
      case (cmd)
        LC_GO:    go_d = 1'b1;
        LC_PAUSE: go_d = 1'b0;
        LC_UP:    up_d = 1'b1;
        LC_DOWN:  up_d = 1'b0;
        LC_CLR:   clr_d = 1'b1;
        LC_RST: begin
          clr_d = 1'b1;
          go_d  = 1'b0;
        end
        default: begin
          ack_d = 1'b0;
          err_d = 1'b1;
        end
      endcase
    end
  end

  assign go      = go_q;
  assign up      = up_q;
  assign clr     = clr_q;
  assign cmd_ack = ack_q;
  assign cmd_err = err_q;

endmodule
